// File: rtl/riscv_rf_pkg.sv
// Shared defaults and helpers for the parametrised RISC-V register file.
package riscv_rf_pkg;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;

    // Address width for a power-of-two register count; a 2-entry file still needs one bit.
    function automatic int rf_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/riscv_rf_rdport.sv
// One read port: predecode-gated address capture, write-first bypass, x0 override
// and an optional decode-stall-gated output register.
module riscv_rf_rdport #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REGOUT   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pd_stall,
    input  logic                  id_stall,
    input  logic [AW-1:0]         src,
    input  logic [NREGS*XLEN-1:0] rf_flat,
    input  logic [NWR*AW-1:0]     dst,
    input  logic [NWR*XLEN-1:0]   dst_d,
    input  logic [NWR-1:0]        we,
    output logic [XLEN-1:0]       q
);

    logic [AW-1:0]   src_q;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
        end else if (!pd_stall) begin
            src_q <= src;
        end
    end

    // Bypass is suppressed while reset is held so the output stays 0 throughout.
    always_comb begin
        raw = rf_flat[src_q*XLEN +: XLEN];
        if (BYPASS != 0 && rst_n) begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && dst[w*AW +: AW] == src_q) begin
                    raw = dst_d[w*XLEN +: XLEN];
                end
            end
        end
        if (ZERO_REG != 0 && src_q == '0) begin
            raw = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (!id_stall) begin
            q_reg <= raw;
        end
    end

    assign q = (REGOUT != 0) ? q_reg : raw;

endmodule

// File: rtl/riscv_rf_mp.sv
// Multi-port register file between decode (read) and writeback (write), with
// optional write-first bypass and registered read data.
module riscv_rf_mp
    import riscv_rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEF,
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REGOUT   = 0,
    parameter int AW       = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pd_stall_i,
    input  logic                id_stall_i,
    input  logic [NRD*AW-1:0]   rf_src_i,
    output logic [NRD*XLEN-1:0] rf_src_q_o,
    input  logic [NWR*AW-1:0]   rf_dst_i,
    input  logic [NWR*XLEN-1:0] rf_dst_d_i,
    input  logic [NWR-1:0]      rf_we_i
);

    logic [XLEN-1:0]       rf [NREGS];
    logic [NREGS*XLEN-1:0] rf_flat;

    // Ascending port order: the last non-blocking write lands, so the higher port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (rf_we_i[w] && !(ZERO_REG != 0 && rf_dst_i[w*AW +: AW] == '0)) begin
                    rf[rf_dst_i[w*AW +: AW]] <= rf_dst_d_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_flat
        assign rf_flat[i*XLEN +: XLEN] = rf[i];
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        riscv_rf_rdport #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .AW       (AW),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS),
            .REGOUT   (REGOUT)
        ) u_rdport (
            .clk      (clk),
            .rst_n    (rst_n),
            .pd_stall (pd_stall_i),
            .id_stall (id_stall_i),
            .src      (rf_src_i[r*AW +: AW]),
            .rf_flat  (rf_flat),
            .dst      (rf_dst_i),
            .dst_d    (rf_dst_d_i),
            .we       (rf_we_i),
            .q        (rf_src_q_o[r*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_riscv_rf_mp.sv
// Directed bench: three 32-bit configurations share stimulus (bypass, no-bypass,
// registered output) and a 64-bit/16-entry/3-read instance covers the parameter sweep.
module tb_riscv_rf_mp;

    logic        clk;
    logic        rst_n;
    logic        pd_stall;
    logic        id_stall;
    logic [9:0]  src;
    logic [9:0]  dst;
    logic [63:0] dst_d;
    logic [1:0]  we;
    logic [63:0] q_a, q_b, q_c;

    logic [11:0]  src_d;
    logic [3:0]   dst_w;
    logic [63:0]  dst_dw;
    logic         we_w;
    logic [191:0] q_w;

    int checks = 0;
    int failures = 0;

    riscv_rf_mp #(.NWR(2), .BYPASS(1), .REGOUT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .pd_stall_i(pd_stall), .id_stall_i(id_stall),
        .rf_src_i(src), .rf_src_q_o(q_a), .rf_dst_i(dst), .rf_dst_d_i(dst_d), .rf_we_i(we));

    riscv_rf_mp #(.NWR(2), .BYPASS(0), .REGOUT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .pd_stall_i(pd_stall), .id_stall_i(id_stall),
        .rf_src_i(src), .rf_src_q_o(q_b), .rf_dst_i(dst), .rf_dst_d_i(dst_d), .rf_we_i(we));

    riscv_rf_mp #(.NWR(2), .BYPASS(1), .REGOUT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .pd_stall_i(pd_stall), .id_stall_i(id_stall),
        .rf_src_i(src), .rf_src_q_o(q_c), .rf_dst_i(dst), .rf_dst_d_i(dst_d), .rf_we_i(we));

    riscv_rf_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1)) u_w (
        .clk(clk), .rst_n(rst_n), .pd_stall_i(pd_stall), .id_stall_i(id_stall),
        .rf_src_i(src_d), .rf_src_q_o(q_w), .rf_dst_i(dst_w), .rf_dst_d_i(dst_dw), .rf_we_i(we_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] walk_exp(input int k);
        logic [63:0] one;
        one = 64'h1;
        return (k == 0) ? 64'h0 : (one << (k*4 + 3));
    endfunction

    initial begin
        rst_n = 1'b0; pd_stall = 1'b0; id_stall = 1'b0;
        src = '0; dst = '0; dst_d = '0; we = '0;
        src_d = '0; dst_w = '0; dst_dw = '0; we_w = 1'b0;
        #1;
        chk_eq("rst_a", q_a, 64'h0);
        chk_eq("rst_b", q_b, 64'h0);
        chk_eq("rst_c", q_c, 64'h0);
        chk_eq("rst_w", q_w[63:0], 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // x0 write, bypass must not leak it
        dst = {5'd0, 5'd0}; dst_d = {32'h0, 32'h12345678}; we = 2'b01;
        #1;
        chk_eq("x0_bypass_a", {32'h0, q_a[31:0]}, 64'h0);
        tick();
        we = '0;
        chk_eq("x0_a", q_a, 64'h0);
        chk_eq("x0_b", q_b, 64'h0);
        tick();
        chk_eq("x0_c", q_c, 64'h0);

        // dual write collision: port 1 wins
        dst = {5'd7, 5'd7}; dst_d = {32'h22, 32'h11}; we = 2'b11;
        tick();
        we = '0; src = {5'd7, 5'd7};
        tick();
        chk_eq("coll_a", q_a, {32'h22, 32'h22});
        chk_eq("coll_b", q_b, {32'h22, 32'h22});
        tick();
        chk_eq("coll_c", q_c, {32'h22, 32'h22});

        // bypass versus no bypass
        dst = {5'd0, 5'd3}; dst_d = {32'h0, 32'hA}; we = 2'b01;
        tick();
        we = '0; src = {5'd7, 5'd3};
        tick();
        chk_eq("old_a", {32'h0, q_a[31:0]}, 64'hA);
        chk_eq("old_b", {32'h0, q_b[31:0]}, 64'hA);
        dst_d = {32'h0, 32'hB}; we = 2'b01;
        #1;
        chk_eq("byp_a", {32'h0, q_a[31:0]}, 64'hB);
        chk_eq("nobyp_b", {32'h0, q_b[31:0]}, 64'hA);
        chk_eq("byp_other_port", {32'h0, q_a[63:32]}, 64'h22);
        tick();
        we = '0;
        chk_eq("new_a", {32'h0, q_a[31:0]}, 64'hB);
        chk_eq("new_b", {32'h0, q_b[31:0]}, 64'hB);
        chk_eq("byp_c", {32'h0, q_c[31:0]}, 64'hB);

        // predecode stall freezes the sampled address
        dst = {5'd9, 5'd4}; dst_d = {32'h99, 32'h44}; we = 2'b11;
        tick();
        we = '0; src = {5'd7, 5'd4};
        tick();
        chk_eq("pd_pre", {32'h0, q_a[31:0]}, 64'h44);
        pd_stall = 1'b1; src = {5'd7, 5'd9};
        tick();
        chk_eq("pd_hold1", {32'h0, q_a[31:0]}, 64'h44);
        tick();
        chk_eq("pd_hold2", {32'h0, q_b[31:0]}, 64'h44);
        pd_stall = 1'b0;
        tick();
        chk_eq("pd_release", {32'h0, q_a[31:0]}, 64'h99);
        tick();
        chk_eq("c_pre_id", {32'h0, q_c[31:0]}, 64'h99);

        // decode stall freezes the registered output for three edges
        src = {5'd7, 5'd3}; id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq($sformatf("id_hold%0d", i), {32'h0, q_c[31:0]}, 64'h99);
        end
        chk_eq("id_a_live", {32'h0, q_a[31:0]}, 64'hB);
        id_stall = 1'b0;
        tick();
        chk_eq("id_release", {32'h0, q_c[31:0]}, 64'hB);

        // mid-cycle asynchronous reset
        dst = {5'd0, 5'd5}; dst_d = {32'h0, 32'hDEADBEEF}; we = 2'b01;
        tick();
        we = '0; src = {5'd7, 5'd5};
        tick();
        chk_eq("x5_pre", {32'h0, q_a[31:0]}, 64'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_a", q_a, 64'h0);
        chk_eq("arst_b", q_b, 64'h0);
        chk_eq("arst_c", q_c, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_eq("post_rst_x5", {32'h0, q_a[31:0]}, 64'h0);
        tick();
        chk_eq("post_rst_x5_b", {32'h0, q_b[31:0]}, 64'h0);
        dst_d = {32'h0, 32'h55}; we = 2'b01;
        tick();
        we = '0;
        chk_eq("rewrite_x5", {32'h0, q_a[31:0]}, 64'h55);

        // walking-ones sweep on the 64-bit, 16-entry, 3-read instance
        for (int i = 0; i < 16; i++) begin
            dst_w = i[3:0];
            dst_dw = 64'h1 << (i*4 + 3);
            we_w = 1'b1;
            tick();
        end
        we_w = 1'b0;
        for (int i = 0; i < 16; i++) begin
            src_d = {4'((i + 5) % 16), 4'((i + 1) % 16), 4'(i)};
            tick();
            chk_eq($sformatf("walk%0d_p0", i), q_w[63:0],    walk_exp(i));
            chk_eq($sformatf("walk%0d_p1", i), q_w[127:64],  walk_exp((i + 1) % 16));
            chk_eq($sformatf("walk%0d_p2", i), q_w[191:128], walk_exp((i + 5) % 16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
